rc_cpl_splitter: RTL

- Receive-side transaction-layer stage that sits directly upstream of the Read Completion R-channel driver.
- Accepts inbound TLP beats from the data link layer and filters for Completion-with-Data (CplD).
- For each CplD, pushes the 128b header into the completion header FIFO and the payload beats, with last marking, into the completion payload FIFO.
- Drops all other TLP types, checks payload length against the header, and keeps simple statistics.

---
 rtl/rc_cpl_splitter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rc_cpl_splitter.sv
// Receive-side CplD splitter: routes completion headers and payload beats into
// their FIFOs, discards other TLPs, and flags payload length/framing errors.
package pcie_pkg;
  localparam int unsigned PIPE_DATA_WIDTH = 256;
endpackage

module rc_cpl_splitter #(
  parameter int unsigned DATA_WIDTH = pcie_pkg::PIPE_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tlp_valid,
  output logic                  tlp_ready,
  input  logic [DATA_WIDTH-1:0] tlp_data,
  input  logic                  tlp_sop,
  input  logic                  tlp_eop,
  input  logic                  hdr_full,
  output logic                  hdr_wren,
  output logic [127:0]          hdr_wdata,
  input  logic                  pay_full,
  output logic                  pay_wren,
  output logic [DATA_WIDTH-1:0] pay_wdata,
  output logic                  pay_wlast,
  output logic [CNT_WIDTH-1:0]  cpl_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  len_err
);

  localparam int unsigned HDR_WIDTH  = 128;
  localparam int unsigned BEAT_WIDTH = 11;

  typedef enum logic [1:0] {IDLE, PAY, DROP} state_t;

  state_t                 state_q, state_d;
  logic [BEAT_WIDTH-1:0]  beats_rem_q, beats_rem_d;
  logic [CNT_WIDTH-1:0]   cpl_cnt_d, drop_cnt_d;
  logic                   len_err_d;
  logic                   accept;
  logic                   is_cpld;
  logic [BEAT_WIDTH-1:0]  len_dw;
  logic [BEAT_WIDTH-1:0]  hdr_beats;

  // DW0 decode; a zero length field encodes 1024 DW
  assign is_cpld   = (tlp_data[31:29] == 3'b010) && (tlp_data[28:24] == 5'b01010);
  assign len_dw    = (tlp_data[9:0] == 10'd0) ? BEAT_WIDTH'(1024) : BEAT_WIDTH'(tlp_data[9:0]);
  assign hdr_beats = BEAT_WIDTH'((len_dw + BEAT_WIDTH'(7)) >> 3);

  assign hdr_wdata = tlp_data[HDR_WIDTH-1:0];
  assign pay_wdata = tlp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beats_rem_q <= '0;
      cpl_cnt     <= '0;
      drop_cnt    <= '0;
      len_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_rem_q <= beats_rem_d;
      cpl_cnt     <= cpl_cnt_d;
      drop_cnt    <= drop_cnt_d;
      len_err     <= len_err_d;
    end
  end

  // Next-state, FIFO write strobes and statistics updates
  always_comb begin
    state_d     = state_q;
    beats_rem_d = beats_rem_q;
    cpl_cnt_d   = cpl_cnt;
    drop_cnt_d  = drop_cnt;
    len_err_d   = 1'b0;
    tlp_ready   = 1'b0;
    accept      = 1'b0;
    hdr_wren    = 1'b0;
    pay_wren    = 1'b0;
    pay_wlast   = 1'b0;
    case (state_q)
      IDLE: begin
        tlp_ready = !hdr_full;
        accept    = tlp_valid && tlp_ready;
        if (accept) begin
          if (!tlp_sop) begin
            len_err_d = 1'b1;
          end else if (!is_cpld) begin
            drop_cnt_d = drop_cnt + CNT_WIDTH'(1);
            if (!tlp_eop) state_d = DROP;
          end else if (tlp_eop) begin
            // CplD with no payload beat cannot be forwarded
            drop_cnt_d = drop_cnt + CNT_WIDTH'(1);
            len_err_d  = 1'b1;
          end else begin
            hdr_wren    = 1'b1;
            beats_rem_d = hdr_beats;
            state_d     = PAY;
          end
        end
      end
      PAY: begin
        tlp_ready = !pay_full;
        accept    = tlp_valid && tlp_ready;
        if (accept) begin
          pay_wren    = 1'b1;
          pay_wlast   = tlp_eop;
          beats_rem_d = (beats_rem_q == '0) ? '0 : beats_rem_q - BEAT_WIDTH'(1);
          len_err_d   = tlp_sop;
          if (tlp_eop) begin
            cpl_cnt_d = cpl_cnt + CNT_WIDTH'(1);
            state_d   = IDLE;
            if (beats_rem_q != BEAT_WIDTH'(1)) len_err_d = 1'b1;
          end
        end
      end
      DROP: begin
        tlp_ready = 1'b1;
        accept    = tlp_valid;
        if (accept && tlp_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
